// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory boot loader.
// Contents: FSM state encoding, default frame marker, and frame field offsets.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte offsets of the frame header fields; the payload starts at OFF_PAYLOAD.
  localparam int unsigned OFF_SYNC    = 0;
  localparam int unsigned OFF_LEN_LO  = 1;
  localparam int unsigned OFF_LEN_HI  = 2;
  localparam int unsigned OFF_PAYLOAD = 3;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/uart_imem_loader_if.sv
// Bundle between the UART byte receiver, the loader and the instruction memory.
//   rx_data/rx_flag          : byte stream from the UART receiver
//   imem_we/addr/wdata       : word write port into instruction memory
//   cpu_hold                 : core reset request while a frame is in flight
//   load_done/load_err       : one-cycle completion pulses
// modport master = the loader, modport slave = the environment around it.
interface uart_imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_flag;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx_data, rx_flag,
    output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    output rx_data, rx_flag,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/uart_imem_loader_timeout.sv
// Inter-byte watchdog for the boot loader: a reloadable down-counter.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   clr_i              : reload to LIMIT-1 (byte seen, or loader idle)
//   en_i               : count down while a frame is open
//   expire_o           : terminal count reached with no reload this cycle
module loader_timeout #(
  parameter int unsigned LIMIT = 5_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned   CW     = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A byte arriving in the expiry cycle reloads the counter and suppresses expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: parses SYNC, LEN_LO, LEN_HI, LEN x 4 payload bytes (LSB first), CHK
// from the UART byte stream and writes the words sequentially into instruction
// memory, holding the core in reset while a frame is open.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (master)       : rx byte stream in; imem write port, cpu_hold,
//                        load_done / load_err pulses out
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for SYNC_BYTE, other bytes dropped
// ST_LEN_LO | next byte is the low length byte
// ST_LEN_HI | next byte is the high length byte, length checked here
// ST_DATA   | assembling payload words, writing each completed word
// ST_CHK    | next byte is the XOR checksum of the payload
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CLKS = 5_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  uart_imem_loader_if.master  bus
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q;
  logic [7:0]        len_lo_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;
  logic [7:0]        chk_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_hold_q;
  logic              load_done_q;
  logic              load_err_q;

  logic [15:0]       len_in;
  logic [ADDR_W:0]   word_cnt_d;
  logic              expire;

  assign len_in     = {bus.rx_data, len_lo_q};
  assign word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);

  loader_timeout #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_timeout (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr_i     (bus.rx_flag || (state_q == ST_IDLE)),
    .en_i      (state_q != ST_IDLE),
    .expire_o  (expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      if (expire) begin
        state_q    <= ST_IDLE;
        cpu_hold_q <= 1'b0;
        load_err_q <= 1'b1;
      end else if (bus.rx_flag) begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state_q    <= ST_LEN_LO;
              cpu_hold_q <= 1'b1;
              chk_q      <= '0;
              byte_cnt_q <= '0;
              word_cnt_q <= '0;
            end
          end
          ST_LEN_LO: begin
            len_lo_q <= bus.rx_data;
            state_q  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            if ({1'b0, len_in} > MAX_WORDS) begin
              state_q    <= ST_IDLE;
              cpu_hold_q <= 1'b0;
              load_err_q <= 1'b1;
            end else if (len_in == 16'd0) begin
              state_q <= ST_CHK;
            end else begin
              len_q   <= len_in[ADDR_W:0];
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            chk_q      <= chk_q ^ bus.rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == LAST_BYTE_IDX) begin
              // Write is registered, so it lands one cycle after the last byte.
              imem_we_q    <= 1'b1;
              imem_wdata_q <= {bus.rx_data, word_q};
              imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              word_cnt_q   <= word_cnt_d;
              if (word_cnt_d == len_q) begin
                state_q <= ST_CHK;
              end
            end else begin
              // Right shift: after three bytes word_q holds {b2, b1, b0}.
              word_q <= {bus.rx_data, word_q[23:8]};
            end
          end
          ST_CHK: begin
            state_q    <= ST_IDLE;
            cpu_hold_q <= 1'b0;
            if (bus.rx_data == chk_q) begin
              load_done_q <= 1'b1;
            end else begin
              load_err_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;
  localparam int unsigned AW   = 10;
  localparam int unsigned TO   = 100;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [1:0]  K_DONE = 2'b01;
  localparam logic [1:0]  K_ERR  = 2'b10;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [1:0] kind; int lo; int hi; } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int max_gap = 2;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  logic [31:0] frame_w[$];
  wr_t mon_w;
  ev_t mon_e;

  uart_imem_loader_if #(.ADDR_W(AW)) bus ();

  uart_imem_loader #(
    .ADDR_W(AW), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a write or pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: got addr %0d data %08h, expected no write", bus.imem_addr, bus.imem_wdata);
        end else begin
          mon_w = exp_wr.pop_front();
          check_eq("wr_addr", 32'(bus.imem_addr), 32'(mon_w.addr));
          check_eq("wr_data", bus.imem_wdata, mon_w.data);
          check_eq("wr_cycle", cyc, mon_w.cyc);
          check_eq("wr_hold", 32'(bus.cpu_hold), 32'd1);
        end
      end
      if (bus.load_done || bus.load_err) begin
        if (exp_ev.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none", bus.load_done, bus.load_err);
        end else begin
          mon_e = exp_ev.pop_front();
          check_eq("ev_kind", 32'({bus.load_err, bus.load_done}), 32'(mon_e.kind));
          check_eq("ev_hold", 32'(bus.cpu_hold), 32'd0);
          n_checks++;
          if (cyc < mon_e.lo || cyc > mon_e.hi) begin
            n_errors++;
            $display("FAIL ev_cycle: got %0d expected %0d..%0d", cyc, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  // Drive one byte for one cycle, starting at a negedge; returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_flag = 1'b1;
    @(negedge clk);
    bus.rx_flag = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  // Reference: checksum is the XOR of every payload byte.
  function automatic logic [7:0] model_chk();
    logic [7:0] x = 8'h00;
    foreach (frame_w[i]) x ^= frame_w[i][7:0] ^ frame_w[i][15:8] ^ frame_w[i][23:16] ^ frame_w[i][31:24];
    return x;
  endfunction

  // Send a frame carrying frame_w with length field len. chk_xor != 0 corrupts the
  // checksum; cut >= 1 stops after that many payload bytes (watchdog path).
  task automatic run_frame(input int len, input logic [7:0] chk_xor, input int cut);
    logic [15:0] lf;
    logic [31:0] w;
    logic [7:0]  b;
    bit last;
    lf = len[15:0];
    send_byte(SYNC);
    check_eq("hold_after_sync", 32'(bus.cpu_hold), 32'd1);
    gap();
    send_byte(lf[7:0]);
    gap();
    if (len > (1 << AW)) begin
      exp_ev.push_back('{kind: K_ERR, lo: cyc + 1, hi: cyc + 1});
      send_byte(lf[15:8]);
      return;
    end
    send_byte(lf[15:8]);
    gap();
    for (int i = 0; i < 4 * len; i++) begin
      w = frame_w[i / 4];
      b = 8'(w >> (8 * (i % 4)));
      last = (cut > 0) && (i == cut - 1);
      if (i % 4 == 3) exp_wr.push_back('{addr: AW'(i / 4), data: w, cyc: cyc + 1});
      if (last) exp_ev.push_back('{kind: K_ERR, lo: cyc + int'(TO), hi: cyc + int'(TO) + 2});
      send_byte(b);
      if (last) return;
      gap();
    end
    exp_ev.push_back('{kind: (chk_xor == 8'h00) ? K_DONE : K_ERR, lo: cyc + 1, hi: cyc + 1});
    send_byte(model_chk() ^ chk_xor);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_wr.size() != 0 || exp_ev.size() != 0); i++) @(negedge clk);
    n_checks++;
    if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d writes %0d pulses outstanding, expected 0", exp_wr.size(), exp_ev.size());
      exp_wr.delete();
      exp_ev.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic random_words(input int n);
    frame_w.delete();
    for (int i = 0; i < n; i++) frame_w.push_back($urandom);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.rx_flag = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_we", 32'(bus.imem_we), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("rst_wdata", bus.imem_wdata, 32'd0);
    check_eq("rst_hold", 32'(bus.cpu_hold), 32'd0);
    check_eq("rst_done", 32'(bus.load_done), 32'd0);
    check_eq("rst_err", 32'(bus.load_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame_w = '{32'h12345678};
    run_frame(1, 8'h00, -1);
    drain(50);

    frame_w = '{32'hDEADBEEF, 32'h00000013};
    run_frame(2, 8'h00, -1);
    drain(50);

    frame_w = '{32'h12345678};
    run_frame(1, 8'h01, -1);
    drain(50);

    run_frame(1025, 8'h00, -1);
    drain(50);
    check_eq("hold_after_overflow", 32'(bus.cpu_hold), 32'd0);

    frame_w = '{32'h12345678};
    run_frame(1, 8'h00, 2);
    drain(3 * TO);
    check_eq("hold_after_timeout", 32'(bus.cpu_hold), 32'd0);
    random_words(3);
    run_frame(3, 8'h00, -1);
    drain(80);

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    @(negedge clk);
    check_eq("hold_after_noise", 32'(bus.cpu_hold), 32'd0);
    frame_w.delete();
    run_frame(0, 8'h00, -1);
    drain(50);

    frame_w = '{32'hA5A5A5A5, 32'h000000A5};
    run_frame(2, 8'h00, -1);
    drain(50);

    send_byte(SYNC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h78);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_hold", 32'(bus.cpu_hold), 32'd0);
    check_eq("midreset_addr", 32'(bus.imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_w = '{32'hCAFEF00D};
    run_frame(1, 8'h00, -1);
    drain(50);

    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 8);
      random_words(n);
      run_frame(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, -1);
      drain(200);
    end

    max_gap = 0;
    random_words(1 << AW);
    run_frame(1 << AW, 8'h00, -1);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
Downstream consumer of the UART byte receiver (8-bit data + 1-cycle valid flag). Parses a framed boot stream and writes 32-bit little-endian words sequentially into instruction memory. Holds the RISC32-SC core in reset while loading. Reports success or failure with one-cycle pulses.

Parameters:
ADDR_W, 10, instruction-memory word-address width; max words = 2**ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 5_000_000, max sys_clk cycles between bytes inside a frame (100 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  asynchronous reset, active low
rx_data  in  8  received byte; valid only when rx_flag=1
rx_flag  in  1  one-cycle byte-valid strobe from the UART receiver
imem_we  out  1  instruction-memory write enable, one-cycle pulse per word
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  word to write
cpu_hold  out  1  high while a frame is in progress; drives core reset
load_done  out  1  one-cycle pulse: frame accepted, checksum good
load_err  out  1  one-cycle pulse: frame aborted (bad checksum, length overflow, timeout)

Behaviour:
- Reset: state=IDLE. All outputs 0, imem_wdata=0, imem_addr=0. Internal counters and checksum are 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then N=LEN words × 4 bytes (LSB first), then CHK. CHK = XOR of all payload bytes, excluding SYNC, LEN and CHK.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK.
  - IDLE: on rx_flag with rx_data==SYNC_BYTE, go to LEN_LO. Other bytes are ignored.
  - LEN_LO: latch low length byte, go to LEN_HI.
  - LEN_HI: latch high length byte and check N.
    - N > 2**ADDR_W: pulse load_err and return to IDLE.
    - N==0: go to CHK.
    - Otherwise: go to DATA.
  - DATA:
    - Each byte is shifted into word bits [8k+7:8k], k=byte_cnt 0..3, and XORed into the checksum.
    - On the 4th byte, on the next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=word_cnt. After that, word_cnt increments.
    - After word N-1 is written, go to CHK.
  - CHK:
    - rx_data==checksum: pulse load_done.
    - Otherwise: pulse load_err.
    - Return to IDLE in both cases.
- cpu_hold goes to 1 in the cycle after the SYNC byte is accepted. It goes to 0 in the same cycle load_done or load_err pulses.
- Timeout:
  - Counter clears on every rx_flag and counts while state≠IDLE.
  - Reaching TIMEOUT_CLKS-1 pulses load_err and forces IDLE.
  - A rx_flag in the same cycle as expiry wins: the byte is processed and the counter clears.
- Write latency: imem_we asserts exactly 1 cycle after the rx_flag carrying byte 3 of a word.
- Counter rules:
  - word_cnt is ADDR_W+1 bits wide, so N=2**ADDR_W is legal; the last address is 2**ADDR_W-1.
  - imem_addr = word_cnt[ADDR_W-1:0].
- Memory contents are not rolled back on error. The core stays held until the pulse; software re-sends the frame.
- Mid-frame reset (sys_rst_n low): immediate return to reset values; cpu_hold drops.
- A SYNC_BYTE value inside LEN/DATA is treated as data, not a restart.

Decomposition:
- Package uart_loader_pkg: state encoding localparams (IDLE..CHK), SYNC_BYTE default, frame field offsets.
- One natural sub-module: loader_timeout, a reloadable down-counter with clear/enable inputs and an expire output.
- The FSM, byte assembler and checksum stay in the top.

Test Plan:
- Frame A5 01 00 78 56 34 12 08 → one imem_we pulse at addr 0, wdata 32'h12345678. Then load_done pulse; cpu_hold high from after A5 until load_done.
- Frame A5 02 00, words 32'hDEADBEEF, 32'h00000013, correct CHK → writes at addr 0 then 1. Each imem_we lands 1 cycle after the 4th byte of its word. load_done pulses.
- Same one-word frame with CHK=09 → word still written. load_err pulses, load_done stays 0, FSM back in IDLE.
- A5 01 04 with ADDR_W=10 (N=1025) → load_err immediately after LEN_HI, no imem_we.
- A5 01 00 78 56, then silence for TIMEOUT_CLKS (set to 100 in sim) → load_err at count expiry, cpu_hold 0. A following valid frame loads normally.
- Leading noise bytes 00 FF 13 before A5, and zero-length frame A5 00 00 00 → noise ignored, no writes, load_done pulses.
